// File: rtl/node_tree_traverser.sv
// K-d tree node store plus a fully pipelined root-to-leaf traversal.
// Nodes are kept in heap order; each pipeline stage resolves one tree level per cycle.
module node_tree_traverser #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int NUM_LEAVES = 64,
    parameter int NUM_QUERYS = 408,
    parameter int LEAF_ADDRW = $clog2(NUM_LEAVES),
    parameter int NUM_NODES  = NUM_LEAVES - 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wbs_node_mem_web,
    input  logic [31:0]                      wbs_node_mem_addr,
    input  logic [31:0]                      wbs_node_mem_wdata,
    output logic [31:0]                      wbs_node_mem_rdata,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0] in_patch,
    input  logic [$clog2(NUM_QUERYS)-1:0]    in_tag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LEAF_ADDRW-1:0]            out_leaf,
    output logic [$clog2(NUM_QUERYS)-1:0]    out_tag,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0] out_patch
);

    localparam int TAG_W   = $clog2(NUM_QUERYS);
    localparam int PATCH_W = PATCH_SIZE * DATA_WIDTH;
    localparam int NODE_AW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int CHILD_W = NODE_AW + 1;

    logic signed [DATA_WIDTH-1:0] node_median [NUM_NODES];
    logic [2:0]                   node_idx    [NUM_NODES];

    logic               addr_hit;
    logic [NODE_AW-1:0] node_sel;
    logic               advance;
    logic               unused_bits;

    assign addr_hit    = (wbs_node_mem_addr < 32'(NUM_NODES));
    assign node_sel    = wbs_node_mem_addr[NODE_AW-1:0];
    assign advance     = ~out_valid | out_ready;
    assign in_ready    = advance;
    assign unused_bits = ^{wbs_node_mem_wdata[31:11+DATA_WIDTH], wbs_node_mem_wdata[10:3]};

    // Reset marks every node invalid (idx=7), which steers all queries to leaf 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                node_median[n] <= '0;
                node_idx[n]    <= 3'b111;
            end
        end else if (!wbs_node_mem_web && addr_hit) begin
            node_median[node_sel] <= wbs_node_mem_wdata[11 +: DATA_WIDTH];
            node_idx[node_sel]    <= wbs_node_mem_wdata[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbs_node_mem_rdata <= 32'h0000_0007;
        end else if (addr_hit) begin
            wbs_node_mem_rdata <= (32'($unsigned(node_median[node_sel])) << 11)
                                | 32'(node_idx[node_sel]);
        end else begin
            wbs_node_mem_rdata <= 32'h0000_0007;
        end
    end

    logic                         st_valid [LEAF_ADDRW];
    logic [NODE_AW-1:0]           st_ptr   [LEAF_ADDRW];
    logic [PATCH_W-1:0]           st_patch [LEAF_ADDRW];
    logic [TAG_W-1:0]             st_tag   [LEAF_ADDRW];
    logic signed [DATA_WIDTH-1:0] sel_elem [LEAF_ADDRW];
    logic                         go_left  [LEAF_ADDRW];
    logic [CHILD_W-1:0]           child    [LEAF_ADDRW];

    // Per-stage branch decision; an out-of-range split index always goes left.
    always_comb begin
        for (int s = 0; s < LEAF_ADDRW; s++) begin
            sel_elem[s] = '0;
            for (int e = 0; e < PATCH_SIZE; e++) begin
                if (node_idx[st_ptr[s]] == 3'(e)) begin
                    sel_elem[s] = st_patch[s][e*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            go_left[s] = (32'(node_idx[st_ptr[s]]) >= 32'(PATCH_SIZE))
                       || (sel_elem[s] < node_median[st_ptr[s]]);
            child[s]   = (CHILD_W'(st_ptr[s]) << 1) + (go_left[s] ? CHILD_W'(1) : CHILD_W'(2));
        end
    end

    // Global stall: every stage and the output register move together or not at all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LEAF_ADDRW; s++) begin
                st_valid[s] <= 1'b0;
                st_ptr[s]   <= '0;
                st_patch[s] <= '0;
                st_tag[s]   <= '0;
            end
            out_valid <= 1'b0;
            out_leaf  <= '0;
            out_tag   <= '0;
            out_patch <= '0;
        end else if (advance) begin
            st_valid[0] <= in_valid;
            st_ptr[0]   <= '0;
            st_patch[0] <= in_patch;
            st_tag[0]   <= in_tag;
            for (int s = 1; s < LEAF_ADDRW; s++) begin
                st_valid[s] <= st_valid[s-1];
                st_ptr[s]   <= child[s-1][NODE_AW-1:0];
                st_patch[s] <= st_patch[s-1];
                st_tag[s]   <= st_tag[s-1];
            end
            out_valid <= st_valid[LEAF_ADDRW-1];
            if (st_valid[LEAF_ADDRW-1]) begin
                out_leaf  <= LEAF_ADDRW'(child[LEAF_ADDRW-1] - CHILD_W'(NUM_NODES));
                out_tag   <= st_tag[LEAF_ADDRW-1];
                out_patch <= st_patch[LEAF_ADDRW-1];
            end
        end
    end

endmodule

// File: tb/tb_node_tree_traverser.sv
// Self-checking bench for node_tree_traverser: table-driven node port and query vectors,
// a scoreboard queue for traversal results, plus stall and mid-flight reset sequences.
module tb_node_tree_traverser;

    localparam int DW  = 11;
    localparam int PS  = 5;
    localparam int NL  = 64;
    localparam int NQ  = 408;
    localparam int LAW = 6;
    localparam int NN  = 63;
    localparam int TW  = 9;
    localparam int PW  = PS * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          web;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_patch;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [LAW-1:0] out_leaf;
    logic [TW-1:0] out_tag;
    logic [PW-1:0] out_patch;

    node_tree_traverser #(
        .DATA_WIDTH(DW), .PATCH_SIZE(PS), .NUM_LEAVES(NL), .NUM_QUERYS(NQ)
    ) dut (
        .clk(clk), .rst(rst),
        .wbs_node_mem_web(web), .wbs_node_mem_addr(addr),
        .wbs_node_mem_wdata(wdata), .wbs_node_mem_rdata(rdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_patch(in_patch), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_leaf(out_leaf),
        .out_tag(out_tag), .out_patch(out_patch)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0]  patch;
        logic [TW-1:0]  tag;
        logic [LAW-1:0] leaf;
        logic           chk_lat;
        int             acc_cyc;
    } sb_t;

    typedef struct {
        logic        web;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_vec_t;

    typedef struct {
        logic signed [DW-1:0] e0;
        logic [TW-1:0]        tag;
        logic [LAW-1:0]       leaf;
    } q_vec_t;

    sb_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  out_count = 0;
    logic pat_on = 1'b0;
    logic stream_chk = 1'b0;
    int   pidx = 0;
    logic [3:0] pat = 4'b1001;

    logic [2:0]           m_idx [NN];
    logic signed [DW-1:0] m_med [NN];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NN; n++) begin
            m_idx[n] = 3'b111;
            m_med[n] = '0;
        end
    endtask

    function automatic logic [LAW-1:0] model_leaf(input logic [PW-1:0] p);
        int n = 0;
        logic signed [DW-1:0] e;
        logic left;
        for (int l = 0; l < LAW; l++) begin
            if (int'(m_idx[n]) < PS) begin
                e = p[int'(m_idx[n])*DW +: DW];
                left = (e < m_med[n]);
            end else begin
                left = 1'b1;
            end
            n = left ? 2*n + 1 : 2*n + 2;
        end
        return LAW'(n - NN);
    endfunction

    function automatic logic [PW-1:0] mk_patch(input logic signed [DW-1:0] e0);
        logic [PW-1:0] p;
        p = PW'({$urandom(), $urandom()});
        p[DW-1:0] = e0;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (pat_on) begin
            out_ready = pat[pidx % 4];
            pidx++;
        end
    endtask

    task automatic write_node(input int a, input logic [2:0] idx, input logic signed [DW-1:0] med);
        web   = 1'b0;
        addr  = 32'(a);
        wdata = {10'b0, med, 8'($urandom()), idx};
        tick();
        web = 1'b1;
        if (a < NN) begin
            m_idx[a] = idx;
            m_med[a] = med;
        end
    endtask

    task automatic applyStimulus(input logic [PW-1:0] p, input logic [TW-1:0] t,
                                 input logic [LAW-1:0] leaf, input logic chk);
        logic accepted = 1'b0;
        int   w = 0;
        in_valid = 1'b1;
        in_patch = p;
        in_tag   = t;
        while (!accepted && w < 100) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{p, t, leaf, chk, cyc});
                accepted = 1'b1;
            end
            tick();
            w++;
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 300) begin
            tick();
            w++;
        end
        checkOutput("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on each output transfer and checks stall behaviour.
    initial begin
        sb_t e;
        logic           held_valid = 1'b0;
        logic [LAW-1:0] h_leaf;
        logic [TW-1:0]  h_tag;
        logic [PW-1:0]  h_patch;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_valid = 1'b0;
            end else begin
                if (stream_chk) checkOutput("in_ready_stall", 64'(in_ready), 64'(!out_valid || out_ready));
                if (held_valid) begin
                    checkOutput("stall_valid", 64'(out_valid), 64'd1);
                    checkOutput("stall_leaf", 64'(out_leaf), 64'(h_leaf));
                    checkOutput("stall_tag", 64'(out_tag), 64'(h_tag));
                    checkOutput("stall_patch", 64'(out_patch), 64'(h_patch));
                end
                held_valid = out_valid && !out_ready;
                h_leaf  = out_leaf;
                h_tag   = out_tag;
                h_patch = out_patch;
                if (out_valid && out_ready) begin
                    out_count++;
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_output", 64'(out_tag), 64'h1_0000);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("out_leaf", 64'(out_leaf), 64'(e.leaf));
                        checkOutput("out_tag", 64'(out_tag), 64'(e.tag));
                        checkOutput("out_patch", 64'(out_patch), 64'(e.patch));
                        // Accept is sampled the negedge before posedge t; output first visible after t+LAW.
                        if (e.chk_lat) checkOutput("latency", 64'(cyc - e.acc_cyc), 64'(LAW + 1));
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mem_vec_t mv[9];
        q_vec_t   qv[10];
        logic [PW-1:0] p;
        int base;
        int stale;

        mv[0] = '{1'b1, 32'd1,  32'h0,                         32'h0000_0007};
        mv[1] = '{1'b1, 32'd62, 32'h0,                         32'h0000_0007};
        mv[2] = '{1'b0, 32'd1,  {10'b0, 11'd55, 11'd1},        32'h0000_0007};
        mv[3] = '{1'b1, 32'd1,  32'h0,                         32'h0001_B801};
        mv[4] = '{1'b0, 32'd63, {10'b0, 11'd99, 11'd2},        32'h0000_0007};
        mv[5] = '{1'b1, 32'd63, 32'h0,                         32'h0000_0007};
        mv[6] = '{1'b0, 32'd62, {10'b0, 11'h7FE, 11'h7FC},     32'h0000_0007};
        mv[7] = '{1'b1, 32'd62, 32'h0,                         32'h003F_F004};
        mv[8] = '{1'b1, 32'h8000_0001, 32'h0,                  32'h0000_0007};

        qv[0] = '{11'sd5,     9'd100, 6'd0};
        qv[1] = '{-11'sd3,    9'd101, 6'd0};
        qv[2] = '{11'sd0,     9'd102, 6'd0};
        qv[3] = '{-11'sd1024, 9'd407, 6'd0};
        qv[4] = '{11'sd5,     9'd1,   6'd63};
        qv[5] = '{-11'sd3,    9'd2,   6'd0};
        qv[6] = '{11'sd0,     9'd3,   6'd63};
        qv[7] = '{11'sd1023,  9'd4,   6'd63};
        qv[8] = '{-11'sd1024, 9'd5,   6'd0};
        qv[9] = '{-11'sd1,    9'd6,   6'd0};

        model_reset();
        rst = 1'b1;
        web = 1'b1;
        addr = 32'd0;
        wdata = 32'd0;
        in_valid = 1'b0;
        in_patch = '0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_leaf", 64'(out_leaf), 64'd0);
        checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
        checkOutput("reset_out_patch", 64'(out_patch), 64'd0);
        checkOutput("reset_rdata", 64'(rdata), 64'h7);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 4; i++) applyStimulus(mk_patch(qv[i].e0), qv[i].tag, qv[i].leaf, 1'b1);
        drain();

        for (int i = 0; i < 9; i++) begin
            web   = mv[i].web;
            addr  = mv[i].addr;
            wdata = mv[i].wdata;
            tick();
            checkOutput($sformatf("rdata_vec%0d", i), 64'(rdata), 64'(mv[i].rdata));
        end
        web = 1'b1;
        m_idx[1] = 3'd1;   m_med[1] = 11'sd55;
        m_idx[62] = 3'd4;  m_med[62] = -11'sd2;

        for (int n = 0; n < NN; n++) write_node(n, 3'd0, 11'sd0);
        for (int i = 4; i < 10; i++) applyStimulus(mk_patch(qv[i].e0), qv[i].tag, qv[i].leaf, 1'b1);
        drain();

        for (int n = 0; n < NN; n++) write_node(n, 3'($urandom_range(0, 7)), DW'($urandom()));
        base = out_count;
        pat_on = 1'b1;
        stream_chk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            p = mk_patch(DW'($urandom()));
            applyStimulus(p, TW'(i), model_leaf(p), 1'b0);
        end
        drain();
        pat_on = 1'b0;
        stream_chk = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_count", 64'(out_count - base), 64'd20);

        for (int i = 0; i < 4; i++) begin
            p = mk_patch(DW'($urandom()));
            applyStimulus(p, TW'(200 + i), model_leaf(p), 1'b0);
        end
        rst = 1'b1;
        #1;
        checkOutput("midflight_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = out_count;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) stale++;
        end
        checkOutput("no_stale_valid", 64'(stale), 64'd0);
        checkOutput("no_stale_transfer", 64'(out_count - base), 64'd0);
        addr = 32'd5;
        tick();
        checkOutput("post_reset_node", 64'(rdata), 64'h7);
        p = mk_patch(11'sd7);
        applyStimulus(p, 9'd321, model_leaf(p), 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/node_tree_traverser.md
Name: node_tree_traverser

Overview:
- Stores the internal k-d tree nodes (split dimension and median per node) as a register array.
- Exposes the node read/write port driven by the Wishbone slave controller's node-memory interface.
- Runs a fully pipelined root-to-leaf traversal: one query patch in, one leaf index out.
- Sits between the Wishbone slave controller / query patch memory (upstream) and the leaf memory / k-NN search stage (downstream).

Parameters:
- DATA_WIDTH, 11, bits per patch element and per median (signed two's complement).
- PATCH_SIZE, 5, elements per query patch.
- NUM_LEAVES, 64, leaves in the tree; must be a power of two, at least 2.
- NUM_QUERYS, 408, query count; sizes the tag field.
- LEAF_ADDRW, $clog2(NUM_LEAVES), leaf index width and number of pipeline levels.
- NUM_NODES, NUM_LEAVES-1, internal node count.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- wbs_node_mem_web  in  1  active-low write enable (0 = write, 1 = read).
- wbs_node_mem_addr  in  32  node index; only the value range matters.
- wbs_node_mem_wdata  in  32  {10'b0, median[10:0], idx[10:0]}; only idx[2:0] is stored.
- wbs_node_mem_rdata  out  32  {10'b0, median, 8'b0, idx[2:0]}.
- in_valid  in  1  query patch valid.
- in_ready  out  1  pipeline can accept a query.
- in_patch  in  PATCH_SIZE*DATA_WIDTH  packed patch; element i is at [i*DATA_WIDTH +: DATA_WIDTH].
- in_tag  in  $clog2(NUM_QUERYS)  query address, passed through unchanged.
- out_valid  out  1  leaf result valid.
- out_ready  in  1  downstream accepts the result.
- out_leaf  out  LEAF_ADDRW  leaf index.
- out_tag  out  $clog2(NUM_QUERYS)  tag of the result.
- out_patch  out  PATCH_SIZE*DATA_WIDTH  patch of the result, for the distance stage.

Behaviour:
- Reset (asynchronous, rst=1):
  - Every node is set to median=0, idx=3'b111 (invalid).
  - wbs_node_mem_rdata=32'h0000_0007.
  - All pipeline valid bits are cleared; out_valid=0, out_leaf=0, out_tag=0, out_patch=0.
  - Reset mid-traversal discards all in-flight queries.
- Node write:
  - Occurs on every posedge with web=0 and addr<NUM_NODES.
  - node[addr] <= {wdata[21:11], wdata[2:0]}.
  - Writes with addr>=NUM_NODES are ignored.
- Node read:
  - rdata is registered every posedge, regardless of web: rdata <= {10'b0, node[addr].median, 8'b0, node[addr].idx}.
  - Latency is 1 cycle.
  - addr>=NUM_NODES returns 32'h0000_0007.
  - Read and write to the same addr in one cycle: rdata shows the old contents; the new value is visible one cycle later.
- Tree layout: heap order. Root is node 0; node n has left child 2n+1 and right child 2n+2.
- Traversal pipeline:
  - LEAF_ADDRW stages; stage s holds a valid bit, node pointer, patch and tag.
  - Stage 0 takes its input from in_*, with pointer=0.
  - Each stage reads its node combinationally from the array.
  - Decision: if idx<PATCH_SIZE and signed(patch[idx]) < signed(median), go left; otherwise go right.
  - Invalid idx (>=PATCH_SIZE) always goes left.
  - Final-stage child pointer minus NUM_NODES is registered into out_leaf.
- Latency: a query accepted at posedge t produces out_valid=1 after posedge t+LEAF_ADDRW, with no stalls.
- Throughput: one query per cycle.
- Flow control:
  - advance = ~out_valid | out_ready; in_ready = advance.
  - On advance=0 all stages and outputs hold (global stall). Valid bubbles are not compressed.
  - A transfer happens when in_valid & in_ready, and likewise when out_valid & out_ready.
  - out_* stay stable while out_valid=1 and out_ready=0.
- Node writes during traversal take effect at the next posedge. A stage evaluating that node in the same cycle uses the old value. There is no interlock; software updates the tree only while idle.

Test Plan:
- Reset, then read addr 1 and addr 62 -> rdata=32'h0000_0007 one cycle after the address is applied.
- Write wdata={10'b0, 11'd55, 11'd1} at addr 1, then read addr 1 -> rdata={10'b0, 11'd55, 8'b0, 3'b001}. Write at addr 63 -> ignored; read of addr 63 returns 32'h0000_0007.
- All nodes at reset (invalid idx) and any patch -> out_leaf=0 exactly 6 cycles after acceptance; out_tag equals in_tag.
- All nodes idx=0, median=11'sd0:
  - patch[0]=+5 -> always right -> out_leaf=63.
  - patch[0]=-3 -> always left -> out_leaf=0.
  - patch[0]=0 -> right (not less than) -> out_leaf=63.
- Back-to-back stream of 20 queries with tags 0..19 and out_ready toggling 1,0,0,1 -> in_ready mirrors the stall; results emerge in order, none lost or duplicated; outputs stay stable while stalled.
- Assert rst for one cycle with 4 queries in flight -> out_valid=0 immediately; nodes return to default; no stale result appears afterwards.
